// File: rtl/nop_packetizer.sv
// nop_packetizer: turns a destination command plus a payload stream into a HEAD/BODY.../TAIL
// wormhole packet. Optional NOP_PKT_LOCALCNT_EN adds LOCALCNT (HEAD flits sent to NODID).
`ifndef DATA_WIDTH
`define DATA_WIDTH 34
`endif
`ifndef DCID_H
`define DCID_H 31
`endif
`ifndef DCID_L
`define DCID_L 28
`endif
`ifndef DRID_H
`define DRID_H 27
`endif
`ifndef DRID_L
`define DRID_L 24
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

// Handshakes (CMD*, PL*, OUT*): a word moves on a rising edge where valid and ready are both
// high; valid never waits on ready, and a presented word holds until it is taken.
module nop_packetizer #(
  parameter int NODID = 0,
  parameter int LEN_W = 4
) (
  input  logic                     CDCLK,
  input  logic                     CDRESETn,
  input  logic [`DCID_H-`DCID_L:0] CMDDCID,
  input  logic [`DRID_H-`DRID_L:0] CMDDRID,
  input  logic [LEN_W-1:0]         CMDLEN,
  input  logic                     CMDVALID,
  output logic                     CMDREADY,
  input  logic [`DATA_WIDTH-3:0]   PLDATA,
  input  logic                     PLVALID,
  output logic                     PLREADY,
  output logic [`DATA_WIDTH-1:0]   OUTDATA,
  output logic                     OUTVALID,
  input  logic                     OUTREADY,
  output logic                     ERRLEN,
`ifdef NOP_PKT_LOCALCNT_EN
  output logic [15:0]              LOCALCNT,
`endif
  output logic                     o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_PAYLOAD = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LEN_W-1:0]       r_cnt, w_cnt_nxt;
  logic [`DATA_WIDTH-1:0] r_outdata, w_outdata_nxt;
  logic                   r_outvalid, w_outvalid_nxt;
  logic                   r_errlen, w_errlen_nxt;
  logic                   w_load_en, w_cmdready, w_plready;

  // The output register may take a new flit whenever it is empty or being drained.
  assign w_load_en = ~r_outvalid | OUTREADY;

  assign CMDREADY    = w_cmdready & CDRESETn;
  assign PLREADY     = w_plready & CDRESETn;
  assign OUTDATA     = r_outdata;
  assign OUTVALID    = r_outvalid;
  assign ERRLEN      = r_errlen;
  assign o_dbg_state = (r_state == S_PAYLOAD);

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_outdata  <= '0;
      r_outvalid <= 1'b0;
      r_errlen   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_outdata  <= w_outdata_nxt;
      r_outvalid <= w_outvalid_nxt;
      r_errlen   <= w_errlen_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_outdata_nxt  = r_outdata;
    w_outvalid_nxt = r_outvalid;
    w_errlen_nxt   = r_errlen;
    w_cmdready     = 1'b0;
    w_plready      = 1'b0;
    // A drained slot empties unless a new flit is loaded below.
    if (w_load_en) w_outvalid_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmdready = w_load_en;
        if (w_load_en && CMDVALID) begin
          if (CMDLEN != '0) begin
            w_outdata_nxt = '0;
            w_outdata_nxt[`DATA_WIDTH-1:`DATA_WIDTH-2] = `HEAD;
            w_outdata_nxt[`DCID_H:`DCID_L] = CMDDCID;
            w_outdata_nxt[`DRID_H:`DRID_L] = CMDDRID;
            w_outvalid_nxt = 1'b1;
            w_cnt_nxt      = CMDLEN;
            w_state_nxt    = S_PAYLOAD;
          end else begin
            w_errlen_nxt = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        w_plready = w_load_en;
        if (w_load_en && PLVALID) begin
          w_outdata_nxt  = {((r_cnt == LEN_W'(1)) ? `TAIL : `BODY), PLDATA};
          w_outvalid_nxt = 1'b1;
          w_cnt_nxt      = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef NOP_PKT_LOCALCNT_EN
  localparam int DCID_W = `DCID_H - `DCID_L + 1;

  logic [15:0] r_localcnt;
  logic        w_local_head_xfer;

  assign w_local_head_xfer = r_outvalid && OUTREADY &&
                             (r_outdata[`DATA_WIDTH-1:`DATA_WIDTH-2] == `HEAD) &&
                             (r_outdata[`DCID_H:`DCID_L] == DCID_W'(NODID));
  assign LOCALCNT = r_localcnt;

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) r_localcnt <= '0;
    else if (w_local_head_xfer && (r_localcnt != 16'hFFFF)) r_localcnt <= r_localcnt + 16'd1;
  end
`else
  logic w_unused_nodid;
  assign w_unused_nodid = (NODID < 0);
`endif

endmodule

// File: tb/tb_nop_packetizer.sv
// tb_nop_packetizer: directed and randomized packets, a transaction-level output model
// compared every cycle, and a stream scoreboard of expected flits.
`ifndef DATA_WIDTH
`define DATA_WIDTH 34
`endif
`ifndef DCID_H
`define DCID_H 31
`endif
`ifndef DCID_L
`define DCID_L 28
`endif
`ifndef DRID_H
`define DRID_H 27
`endif
`ifndef DRID_L
`define DRID_L 24
`endif
`ifndef HEAD
`define HEAD 2'b01
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_nop_packetizer;
  localparam int LEN_W = 4;
  localparam int DW    = `DATA_WIDTH;
  localparam int NODID = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    CMDDCID = '0;
  logic [3:0]    CMDDRID = '0;
  logic [LEN_W-1:0] CMDLEN = '0;
  logic          CMDVALID = 1'b0;
  logic          CMDREADY;
  logic [DW-3:0] PLDATA = '0;
  logic          PLVALID = 1'b0;
  logic          PLREADY;
  logic [DW-1:0] OUTDATA;
  logic          OUTVALID;
  logic          OUTREADY = 1'b1;
  logic          ERRLEN;
  logic          dbg_state;
`ifdef NOP_PKT_LOCALCNT_EN
  logic [15:0]   LOCALCNT;
`endif

  nop_packetizer #(.NODID(NODID), .LEN_W(LEN_W)) dut (
    .CDCLK(clk), .CDRESETn(rst_n),
    .CMDDCID(CMDDCID), .CMDDRID(CMDDRID), .CMDLEN(CMDLEN),
    .CMDVALID(CMDVALID), .CMDREADY(CMDREADY),
    .PLDATA(PLDATA), .PLVALID(PLVALID), .PLREADY(PLREADY),
    .OUTDATA(OUTDATA), .OUTVALID(OUTVALID), .OUTREADY(OUTREADY),
    .ERRLEN(ERRLEN),
`ifdef NOP_PKT_LOCALCNT_EN
    .LOCALCNT(LOCALCNT),
`endif
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pcyc    = 0;
  always @(posedge clk) pcyc++;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] log_q[$];
  int            log_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_head(input int dcid, input int drid);
    logic [DW-1:0] f;
    f = DW'(`HEAD) << (DW - 2);
    f = f | (DW'(dcid & 15) << `DCID_L);
    f = f | (DW'(drid & 15) << `DRID_L);
    return f;
  endfunction

  function automatic logic [DW-1:0] mk_pl(input logic [DW-3:0] d, input bit last);
    return {(last ? `TAIL : `BODY), d};
  endfunction

  // ---------------- behavioural model ----------------
  // Transaction view: the output slot holds at most one flit; a packet owes m_rem payloads.
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_rem;
  logic          m_err;
  int            m_local;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_rem = 0; m_err = 1'b0; m_local = 0;
    end else begin
      bit can_take;
      can_take = !m_valid || OUTREADY;
      if (m_valid && OUTREADY && m_data[DW-1:DW-2] == `HEAD &&
          int'(m_data[`DCID_H:`DCID_L]) == NODID && m_local < 65535)
        m_local++;
      if (can_take) begin
        m_valid = 1'b0;
        if (m_rem == 0 && CMDVALID) begin
          if (CMDLEN == 0) m_err = 1'b1;
          else begin
            m_valid = 1'b1; m_data = mk_head(int'(CMDDCID), int'(CMDDRID)); m_rem = int'(CMDLEN);
          end
        end else if (m_rem != 0 && PLVALID) begin
          m_valid = 1'b1; m_data = mk_pl(PLDATA, m_rem == 1); m_rem--;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outvalid", 64'(OUTVALID), 64'(0));
      chk("rst_outdata", 64'(OUTDATA), 64'(0));
      chk("rst_cmdready", 64'(CMDREADY), 64'(0));
      chk("rst_plready", 64'(PLREADY), 64'(0));
      chk("rst_errlen", 64'(ERRLEN), 64'(0));
    end else begin
      chk("outvalid", 64'(OUTVALID), 64'(m_valid));
      if (m_valid) chk("outdata", 64'(OUTDATA), 64'(m_data));
      chk("cmdready", 64'(CMDREADY), 64'(m_rem == 0 && (!m_valid || OUTREADY)));
      chk("plready", 64'(PLREADY), 64'(m_rem != 0 && (!m_valid || OUTREADY)));
      chk("errlen", 64'(ERRLEN), 64'(m_err));
      chk("dbg_state", 64'(dbg_state), 64'(m_rem != 0));
`ifdef NOP_PKT_LOCALCNT_EN
      chk("localcnt", 64'(LOCALCNT), 64'(m_local));
`endif
      if (OUTVALID && OUTREADY) begin
        log_q.push_back(OUTDATA);
        log_cyc.push_back(pcyc);
        if (exp_q.size() == 0) chk("stream_extra", 64'(OUTDATA), 64'(0) - 64'(1));
        else chk("stream", 64'(OUTDATA), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- OUTREADY driver ----------------
  int            rdy_mode   = 0;   // 0 always ready, 1 random, 2 stall on stall_pat
  logic [DW-1:0] stall_pat  = '0;
  int            stall_left = 0;
  bit            stall_done = 1'b0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: OUTREADY = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          OUTREADY = 1'b0; stall_left--;
        end else begin
          OUTREADY = 1'b1;
          if (!stall_done && OUTVALID && OUTDATA == stall_pat) begin
            OUTREADY = 1'b0; stall_left = 2; stall_done = 1'b1;
          end
        end
      end
      default: OUTREADY = 1'b1;
    endcase
  end

  // ---------------- input driver tasks ----------------
  int last_cmd_fire = 0;

  task automatic idle_gap(input int max_gap);
    int g;
    g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic drive_cmd(input int dcid, input int drid, input int len, input int max_gap);
    bit done;
    int t;
    done = 1'b0; t = 0;
    idle_gap(max_gap);
    CMDDCID = 4'(dcid); CMDDRID = 4'(drid); CMDLEN = LEN_W'(len); CMDVALID = 1'b1;
    if (len != 0) exp_q.push_back(mk_head(dcid, drid));
    while (!done) begin
      @(negedge clk);
      done = CMDREADY;
      if (done) last_cmd_fire = pcyc;
      @(posedge clk); #1;
      t++;
      if (!done && t > 300) begin chk("cmd_timeout", 64'(t), 64'(0)); done = 1'b1; end
    end
    CMDVALID = 1'b0;
  endtask

  task automatic drive_pl(input logic [DW-3:0] d, input bit last, input int max_gap);
    bit done;
    int t;
    done = 1'b0; t = 0;
    idle_gap(max_gap);
    PLDATA = d; PLVALID = 1'b1;
    exp_q.push_back(mk_pl(d, last));
    while (!done) begin
      @(negedge clk);
      done = PLREADY;
      @(posedge clk); #1;
      t++;
      if (!done && t > 300) begin chk("pl_timeout", 64'(t), 64'(0)); done = 1'b1; end
    end
    PLVALID = 1'b0;
  endtask

  task automatic send_packet(input int dcid, input int drid, input int len,
                             input logic [DW-3:0] base, input int max_gap);
    drive_cmd(dcid, drid, len, max_gap);
    for (int i = 0; i < len; i++) drive_pl(base + (DW-2)'(i), i == len - 1, max_gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin @(posedge clk); #1; t++; end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_reset();
    CMDVALID = 1'b0; PLVALID = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_idx;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmdready", 64'(CMDREADY), 64'(1));
    @(posedge clk); #1;

    // Basic packet: HEAD(2,5), BODY A, BODY B, TAIL C on consecutive cycles.
    base_idx = log_q.size();
    send_packet(2, 5, 3, 32'hA000_0000, 0);
    drain();
    chk("basic_head", 64'(log_q[base_idx]), 64'h1_2500_0000);
    chk("basic_body_a", 64'(log_q[base_idx + 1]), 64'h0_A000_0000);
    chk("basic_tail_c", 64'(log_q[base_idx + 3]), 64'h2_A000_0002);
    chk("basic_head_lat", 64'(log_cyc[base_idx]), 64'(last_cmd_fire + 1));
    chk("basic_span", 64'(log_cyc[base_idx + 3] - log_cyc[base_idx]), 64'(3));

    // Back-to-back LEN=1 packets: no bubble between them.
    base_idx = log_q.size();
    send_packet(7, 1, 1, 32'h1111_0000, 0);
    send_packet(9, 2, 1, 32'h2222_0000, 0);
    drain();
    chk("b2b_tail_x", 64'(log_q[base_idx + 1]), 64'h2_1111_0000);
    chk("b2b_span", 64'(log_cyc[base_idx + 3] - log_cyc[base_idx]), 64'(3));

    // Backpressure: OUTREADY low for 3 cycles while BODY B is presented.
    rdy_mode = 2; stall_pat = 34'h0_B000_0001; stall_done = 1'b0;
    base_idx = log_q.size();
    send_packet(4, 4, 3, 32'hB000_0000, 0);
    drain();
    chk("bp_stalled", 64'(stall_done), 64'(1));
    chk("bp_b_after_a", 64'(log_cyc[base_idx + 2] - log_cyc[base_idx + 1]), 64'(4));
    chk("bp_tail_c", 64'(log_q[base_idx + 3]), 64'h2_B000_0002);
    rdy_mode = 0;

    // Zero length followed by a normal LEN=2 packet.
    base_idx = log_q.size();
    send_packet(1, 1, 0, '0, 0);
    send_packet(6, 3, 2, 32'hC000_0000, 0);
    drain();
    chk("zero_errlen", 64'(ERRLEN), 64'(1));
    chk("zero_first_is_head", 64'(log_q[base_idx]), 64'h1_6300_0000);

    // Payload-only stream in IDLE never emits flits.
    PLVALID = 1'b1; PLDATA = 32'hDEAD_BEEF;
    repeat (5) begin @(posedge clk); #1; end
    PLVALID = 1'b0;
    chk("plonly_quiet", 64'(OUTVALID), 64'(0));

    // Reset mid-packet.
    drive_cmd(5, 5, 4, 0);
    drive_pl(32'hE000_0000, 1'b0, 0);
    drive_pl(32'hE000_0001, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1 chk("midrst_outvalid", 64'(OUTVALID), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmdready", 64'(CMDREADY), 64'(1));
    chk("midrst_idle", 64'(dbg_state), 64'(0));
    chk("midrst_errlen", 64'(ERRLEN), 64'(0));
    @(posedge clk); #1;
    send_packet(8, 8, 1, 32'hF000_0000, 0);
    drain();

    // Randomized traffic with random backpressure and input gaps.
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      send_packet($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  (DW-2)'($urandom), 2);
    end
    drain();
    rdy_mode = 0;

    // Local-destination count after reset: DCID 3, 1, 3.
    pulse_reset();
    send_packet(3, 0, 2, 32'h3000_0000, 0);
    send_packet(1, 0, 1, 32'h1000_0000, 0);
    send_packet(3, 1, 1, 32'h3100_0000, 0);
    drain();
    repeat (2) begin @(posedge clk); #1; end
`ifdef NOP_PKT_LOCALCNT_EN
    chk("localcnt_final", 64'(LOCALCNT), 64'(2));
`endif
    chk("final_outvalid", 64'(OUTVALID), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
